ec_scalar_mul_ctrl: RTL and testbench

- Sequencer placed directly upstream of the EC point-add/double core (EC_TOP). It computes R = k·P over GF(p) on y² = x³ + a·x + b.
- Uses MSB-first double-and-add. Each add or double is issued to the core over its existing in_valid / out_valid handshake, and the core's result is consumed when it returns.
- The block handles the point at infinity and P + (−P) internally, because the core cannot represent or produce them.

---
 rtl/ec_scalar_mul_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_ec_scalar_mul_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ec_scalar_mul_ctrl.sv
// ec_scalar_mul_ctrl: MSB-first double-and-add sequencer computing R = k*P
// over GF(p). Each point double/add is issued to a downstream EC core over a
// valid/valid handshake. Infinity and P + (-P) are resolved locally because the
// core cannot represent them.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   in_valid, in_k, in_Px, in_Py,    job request (one-cycle pulse, accepted
//   in_prime, in_a                   only while idle)
//   ec_in_valid, ec_Px/Py/Qx/Qy,     core request pulse and operands (held
//   ec_prime, ec_a                   until the core responds)
//   ec_out_valid, ec_Rx, ec_Ry       core response
//   out_valid, out_Rx, out_Ry,       one-cycle result; coordinates are zero
//   out_inf                          when the result is the point at infinity
module ec_scalar_mul_ctrl #(
  parameter int unsigned W  = 6,
  parameter int unsigned KW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [KW-1:0] in_k,
  input  logic [W-1:0]  in_Px,
  input  logic [W-1:0]  in_Py,
  input  logic [W-1:0]  in_prime,
  input  logic [W-1:0]  in_a,
  output logic          ec_in_valid,
  output logic [W-1:0]  ec_Px,
  output logic [W-1:0]  ec_Py,
  output logic [W-1:0]  ec_Qx,
  output logic [W-1:0]  ec_Qy,
  output logic [W-1:0]  ec_prime,
  output logic [W-1:0]  ec_a,
  input  logic          ec_out_valid,
  input  logic [W-1:0]  ec_Rx,
  input  logic [W-1:0]  ec_Ry,
  output logic          out_valid,
  output logic [W-1:0]  out_Rx,
  output logic [W-1:0]  out_Ry,
  output logic          out_inf
);

  localparam int unsigned IW = (KW > 1) ? $clog2(KW) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DBL, S_DBL_WAIT, S_ADD, S_ADD_WAIT, S_NEXT, S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   ax_q, ax_d, ay_q, ay_d;
  logic           ainf_q, ainf_d;
  logic [KW-1:0]  k_q, k_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   px_q, px_d, py_q, py_d, prime_q, prime_d, a_q, a_d;

  logic           ec_vld_q, ec_vld_d;
  logic [W-1:0]   ec_px_q, ec_px_d, ec_py_q, ec_py_d;
  logic [W-1:0]   ec_qx_q, ec_qx_d, ec_qy_q, ec_qy_d;
  logic           out_vld_q, out_vld_d, out_inf_q, out_inf_d;
  logic [W-1:0]   out_rx_q, out_rx_d, out_ry_q, out_ry_d;

  // Shared decisions: doubling infinity or a y=0 point yields infinity;
  // adding with equal x is either a tangent (same point) or P + (-P).
  logic dbl_skip_c, bit_c, add_chord_c, add_tan_c;
  assign dbl_skip_c  = ainf_q | (ay_q == '0);
  assign bit_c       = k_q[idx_q];
  assign add_chord_c = (ax_q != px_q);
  assign add_tan_c   = (ax_q == px_q) && (ay_q == py_q) && (ay_q != '0);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ax_q      <= '0;
      ay_q      <= '0;
      ainf_q    <= 1'b0;
      k_q       <= '0;
      idx_q     <= '0;
      px_q      <= '0;
      py_q      <= '0;
      prime_q   <= '0;
      a_q       <= '0;
      ec_vld_q  <= 1'b0;
      ec_px_q   <= '0;
      ec_py_q   <= '0;
      ec_qx_q   <= '0;
      ec_qy_q   <= '0;
      out_vld_q <= 1'b0;
      out_rx_q  <= '0;
      out_ry_q  <= '0;
      out_inf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ax_q      <= ax_d;
      ay_q      <= ay_d;
      ainf_q    <= ainf_d;
      k_q       <= k_d;
      idx_q     <= idx_d;
      px_q      <= px_d;
      py_q      <= py_d;
      prime_q   <= prime_d;
      a_q       <= a_d;
      ec_vld_q  <= ec_vld_d;
      ec_px_q   <= ec_px_d;
      ec_py_q   <= ec_py_d;
      ec_qx_q   <= ec_qx_d;
      ec_qy_q   <= ec_qy_d;
      out_vld_q <= out_vld_d;
      out_rx_q  <= out_rx_d;
      out_ry_q  <= out_ry_d;
      out_inf_q <= out_inf_d;
    end
  end

  // Next state and accumulator/scalar bookkeeping
  always_comb begin
    state_d = state_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    ainf_d  = ainf_q;
    k_d     = k_q;
    idx_d   = idx_q;
    px_d    = px_q;
    py_d    = py_q;
    prime_d = prime_q;
    a_d     = a_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          k_d     = in_k;
          px_d    = in_Px;
          py_d    = in_Py;
          prime_d = in_prime;
          a_d     = in_a;
          ax_d    = '0;
          ay_d    = '0;
          ainf_d  = 1'b1;
          idx_d   = IW'(KW - 1);
          state_d = S_DBL;
        end
      end
      S_DBL: begin
        if (dbl_skip_c) begin
          ainf_d  = 1'b1;
          state_d = S_ADD;
        end else begin
          state_d = S_DBL_WAIT;
        end
      end
      S_DBL_WAIT: begin
        if (ec_out_valid) begin
          ax_d    = ec_Rx;
          ay_d    = ec_Ry;
          ainf_d  = 1'b0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        if (!bit_c) begin
          state_d = S_NEXT;
        end else if (ainf_q) begin
          ax_d    = px_q;
          ay_d    = py_q;
          ainf_d  = 1'b0;
          state_d = S_NEXT;
        end else if (add_chord_c || add_tan_c) begin
          state_d = S_ADD_WAIT;
        end else begin
          ainf_d  = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_ADD_WAIT: begin
        if (ec_out_valid) begin
          ax_d    = ec_Rx;
          ay_d    = ec_Ry;
          ainf_d  = 1'b0;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx_q == '0) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q - IW'(1);
          state_d = S_DBL;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Core requests and result; operands hold their value between requests
  always_comb begin
    ec_vld_d  = 1'b0;
    ec_px_d   = ec_px_q;
    ec_py_d   = ec_py_q;
    ec_qx_d   = ec_qx_q;
    ec_qy_d   = ec_qy_q;
    out_vld_d = 1'b0;
    out_rx_d  = '0;
    out_ry_d  = '0;
    out_inf_d = 1'b0;
    unique case (state_q)
      S_DBL: begin
        if (!dbl_skip_c) begin
          ec_vld_d = 1'b1;
          ec_px_d  = ax_q;
          ec_py_d  = ay_q;
          ec_qx_d  = ax_q;
          ec_qy_d  = ay_q;
        end
      end
      S_ADD: begin
        if (bit_c && !ainf_q) begin
          if (add_chord_c) begin
            ec_vld_d = 1'b1;
            ec_px_d  = ax_q;
            ec_py_d  = ay_q;
            ec_qx_d  = px_q;
            ec_qy_d  = py_q;
          end else if (add_tan_c) begin
            ec_vld_d = 1'b1;
            ec_px_d  = ax_q;
            ec_py_d  = ay_q;
            ec_qx_d  = ax_q;
            ec_qy_d  = ay_q;
          end
        end
      end
      S_DONE: begin
        out_vld_d = 1'b1;
        out_inf_d = ainf_q;
        if (!ainf_q) begin
          out_rx_d = ax_q;
          out_ry_d = ay_q;
        end
      end
      default: ;
    endcase
  end

  assign ec_in_valid = ec_vld_q;
  assign ec_Px       = ec_px_q;
  assign ec_Py       = ec_py_q;
  assign ec_Qx       = ec_qx_q;
  assign ec_Qy       = ec_qy_q;
  assign ec_prime    = prime_q;
  assign ec_a        = a_q;
  assign out_valid   = out_vld_q;
  assign out_Rx      = out_rx_q;
  assign out_Ry      = out_ry_q;
  assign out_inf     = out_inf_q;

endmodule

// File: tb/tb_ec_scalar_mul_ctrl.sv
// Bench for ec_scalar_mul_ctrl: behavioural EC core with random latency, a
// reference k*P by repeated point addition, and a scoreboard of expected results.
module tb_ec_scalar_mul_ctrl;

  localparam int unsigned W  = 6;
  localparam int unsigned KW = 6;

  typedef struct {
    int x;
    int y;
    bit inf;
  } pt_t;

  typedef struct {
    int px;
    int py;
    int qx;
    int qy;
    int prime;
    int a;
  } req_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [KW-1:0] in_k;
  logic [W-1:0]  in_Px, in_Py, in_prime, in_a;
  logic          ec_in_valid;
  logic [W-1:0]  ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a;
  logic          ec_out_valid;
  logic [W-1:0]  ec_Rx, ec_Ry;
  logic          out_valid;
  logic [W-1:0]  out_Rx, out_Ry;
  logic          out_inf;

  logic          core_vld, late_vld;
  logic [W-1:0]  core_rx, core_ry, late_rx, late_ry;

  assign ec_out_valid = core_vld | late_vld;
  assign ec_Rx        = core_vld ? core_rx : late_rx;
  assign ec_Ry        = core_vld ? core_ry : late_ry;

  always #5 clk = ~clk;

  ec_scalar_mul_ctrl #(.W(W), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_k(in_k), .in_Px(in_Px), .in_Py(in_Py),
    .in_prime(in_prime), .in_a(in_a),
    .ec_in_valid(ec_in_valid), .ec_Px(ec_Px), .ec_Py(ec_Py),
    .ec_Qx(ec_Qx), .ec_Qy(ec_Qy), .ec_prime(ec_prime), .ec_a(ec_a),
    .ec_out_valid(ec_out_valid), .ec_Rx(ec_Rx), .ec_Ry(ec_Ry),
    .out_valid(out_valid), .out_Rx(out_Rx), .out_Ry(out_Ry), .out_inf(out_inf)
  );

  int   checks = 0;
  int   errors = 0;
  pt_t  exp_q[$];
  req_t req_log[$];
  bit   core_en;
  bit   script_en;
  pt_t  script_pt;
  int   core_bad = 0;
  int   ov_cnt = 0;
  int   idle_bad = 0;

  // ---------------- reference arithmetic ----------------
  function automatic int md(input int v, input int p);
    return ((v % p) + p) % p;
  endfunction

  function automatic int inv(input int v, input int p);
    for (int i = 1; i < p; i++) if (md(v * i, p) == 1) return i;
    return 0;
  endfunction

  function automatic pt_t ec_add(input pt_t u, input pt_t v, input int p, input int a);
    pt_t r;
    int  lam;
    r.x = 0; r.y = 0; r.inf = 1'b1;
    if (u.inf) return v;
    if (v.inf) return u;
    if (u.x == v.x) begin
      if (md(u.y + v.y, p) == 0) return r;
      lam = md(md(3 * u.x * u.x + a, p) * inv(md(2 * u.y, p), p), p);
    end else begin
      lam = md(md(v.y - u.y, p) * inv(md(v.x - u.x, p), p), p);
    end
    r.inf = 1'b0;
    r.x = md(lam * lam - u.x - v.x, p);
    r.y = md(lam * md(u.x - r.x, p) - u.y, p);
    return r;
  endfunction

  // k*P by plain repeated addition
  function automatic pt_t ec_mul(input int k, input pt_t pp, input int p, input int a);
    pt_t r;
    r.x = 0; r.y = 0; r.inf = 1'b1;
    for (int i = 0; i < k; i++) r = ec_add(r, pp, p, a);
    return r;
  endfunction

  function automatic pt_t mk(input int x, input int y, input bit inf);
    pt_t r;
    r.x = x; r.y = y; r.inf = inf;
    return r;
  endfunction

  // ---------------- behavioural core ----------------
  initial begin
    req_t r;
    pt_t  res, u, v;
    int   lat;
    core_vld = 1'b0; core_rx = '0; core_ry = '0;
    forever begin
      @(negedge clk);
      if (core_en && ec_in_valid === 1'b1) begin
        r.px = int'(ec_Px); r.py = int'(ec_Py); r.qx = int'(ec_Qx); r.qy = int'(ec_Qy);
        r.prime = int'(ec_prime); r.a = int'(ec_a);
        req_log.push_back(r);
        u = mk(r.px, r.py, 1'b0);
        v = mk(r.qx, r.qy, 1'b0);
        res = script_en ? script_pt : ec_add(u, v, r.prime, r.a);
        lat = $urandom_range(1, 3);
        for (int i = 1; i < lat; i++) begin
          @(negedge clk);
          if (ec_in_valid !== 1'b0) begin
            core_bad++;
            $display("FAIL core_overlap request while busy at %0t", $time);
          end
        end
        if (ec_Px !== W'(r.px) || ec_Py !== W'(r.py) || ec_Qx !== W'(r.qx) || ec_Qy !== W'(r.qy)) begin
          core_bad++;
          $display("FAIL core_operand_hold got (%0d,%0d,%0d,%0d) want (%0d,%0d,%0d,%0d)",
                   ec_Px, ec_Py, ec_Qx, ec_Qy, r.px, r.py, r.qx, r.qy);
        end
        core_rx  = W'(res.x);
        core_ry  = W'(res.y);
        core_vld = 1'b1;
        @(negedge clk);
        if (ec_in_valid !== 1'b0) begin
          core_bad++;
          $display("FAIL core_overlap request during response at %0t", $time);
        end
        core_vld = 1'b0;
      end
    end
  end

  // Result pulse counter and idle-zero watcher
  always @(negedge clk) begin
    if (out_valid === 1'b1) ov_cnt <= ov_cnt + 1;
    else if (rst_n === 1'b1 && (out_Rx !== '0 || out_Ry !== '0 || out_inf !== 1'b0))
      idle_bad <= idle_bad + 1;
  end

  // One job: push expectation, drive request, pop and compare on out_valid.
  // busy_at > 0 pulses a conflicting in_valid that many cycles into the job.
  task automatic run_op(input string name, input int k, input int px, input int py,
                        input int p, input int a, input pt_t expv, input int busy_at,
                        output int ncalls, output int lat);
    int  r0, ov0, bad0;
    bit  done;
    pt_t e;
    r0 = req_log.size(); ov0 = ov_cnt; bad0 = core_bad;
    exp_q.push_back(expv);
    @(negedge clk);
    in_valid = 1'b1; in_k = KW'(k); in_Px = W'(px); in_Py = W'(py);
    in_prime = W'(p); in_a = W'(a);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0; done = 1'b0;
    while (!done && lat < 2000) begin
      if (out_valid === 1'b1) done = 1'b1;
      else begin
        @(negedge clk);
        lat++;
        if (busy_at > 0 && lat == busy_at) begin
          in_valid = 1'b1; in_k = KW'(1); in_Px = W'(3); in_Py = W'(3);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout no out_valid within %0d cycles", name, lat);
    end else if (out_inf !== e.inf || out_Rx !== W'(e.x) || out_Ry !== W'(e.y)) begin
      errors++;
      $display("FAIL %s_result got (%0d,%0d,inf=%0d) want (%0d,%0d,inf=%0d)",
               name, out_Rx, out_Ry, out_inf, e.x, e.y, e.inf);
    end
    ncalls = req_log.size() - r0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse_width out_valid=%0d want 0", name, out_valid);
    end
    @(negedge clk);
    checks++;
    if (ov_cnt != ov0 + 1) begin
      errors++;
      $display("FAIL %s_pulse_count got %0d want 1", name, ov_cnt - ov0);
    end
    checks++;
    if (core_bad != bad0) begin
      errors++;
      $display("FAIL %s_core_protocol violations %0d want 0", name, core_bad - bad0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ec_in_valid !== 1'b0 || out_valid !== 1'b0 || out_inf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ec_in_valid=%0d out_valid=%0d out_inf=%0d want 0",
               ec_in_valid, out_valid, out_inf);
    end
    checks++;
    if ({ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a} !== '0) begin
      errors++;
      $display("FAIL reset_ec_data got %h want 0", {ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a});
    end
    checks++;
    if (out_Rx !== '0 || out_Ry !== '0) begin
      errors++;
      $display("FAIL reset_out_data got (%0d,%0d) want (0,0)", out_Rx, out_Ry);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n, lat, r0;
    run_op("k0", 0, 1, 1, 5, 1, mk(0, 0, 1'b1), 0, n, lat);
    checks++;
    if (lat != 19) begin errors++; $display("FAIL k0_latency got %0d want 19", lat); end
    checks++;
    if (n != 0) begin errors++; $display("FAIL k0_calls got %0d want 0", n); end

    run_op("k1", 1, 1, 1, 5, 1, mk(1, 1, 1'b0), 0, n, lat);
    checks++;
    if (n != 0 || lat != 19) begin
      errors++; $display("FAIL k1_calls_latency got calls=%0d lat=%0d want 0/19", n, lat);
    end

    r0 = req_log.size();
    run_op("k2", 2, 1, 1, 5, 1, mk(2, 2, 1'b0), 0, n, lat);
    checks++;
    if (n != 1) begin
      errors++; $display("FAIL k2_calls got %0d want 1", n);
    end else if (req_log[r0].px != 1 || req_log[r0].py != 1 || req_log[r0].qx != 1 ||
                 req_log[r0].qy != 1 || req_log[r0].prime != 5 || req_log[r0].a != 1) begin
      errors++;
      $display("FAIL k2_request got P=(%0d,%0d) Q=(%0d,%0d) p=%0d a=%0d want (1,1)(1,1) 5 1",
               req_log[r0].px, req_log[r0].py, req_log[r0].qx, req_log[r0].qy,
               req_log[r0].prime, req_log[r0].a);
    end

    r0 = req_log.size();
    run_op("k3", 3, 1, 1, 5, 1, mk(3, 2, 1'b0), 0, n, lat);
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL k3_calls got %0d want 2", n);
    end else if (req_log[r0 + 1].px != 2 || req_log[r0 + 1].py != 2 ||
                 req_log[r0 + 1].qx != 1 || req_log[r0 + 1].qy != 1) begin
      errors++;
      $display("FAIL k3_add_request got P=(%0d,%0d) Q=(%0d,%0d) want (2,2)(1,1)",
               req_log[r0 + 1].px, req_log[r0 + 1].py, req_log[r0 + 1].qx, req_log[r0 + 1].qy);
    end
  endtask

  task automatic test_infinity();
    int n, lat;
    run_op("y_zero", 2, 2, 0, 5, 1, mk(0, 0, 1'b1), 0, n, lat);
    checks++;
    if (n != 0) begin errors++; $display("FAIL y_zero_calls got %0d want 0", n); end
    // Core claims 2*(1,1) = (1,4): then adding (1,1) is P + (-P)
    script_en = 1'b1;
    script_pt = mk(1, 4, 1'b0);
    run_op("neg_add", 3, 1, 1, 5, 1, mk(0, 0, 1'b1), 0, n, lat);
    script_en = 1'b0;
    checks++;
    if (n != 1) begin errors++; $display("FAIL neg_add_calls got %0d want 1", n); end
  endtask

  task automatic test_back_to_back();
    int n, lat;
    run_op("busy_ign", 3, 1, 1, 5, 1, mk(3, 2, 1'b0), 5, n, lat);
    run_op("b2b", 2, 1, 1, 5, 1, mk(2, 2, 1'b0), 0, n, lat);
  endtask

  task automatic test_reset_abort();
    int  n, lat, cnt, ov0;
    bit  seen, stray;
    core_en = 1'b0;
    ov0 = ov_cnt;
    @(negedge clk);
    in_valid = 1'b1; in_k = KW'(2); in_Px = W'(1); in_Py = W'(1);
    in_prime = W'(5); in_a = W'(1);
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0; cnt = 0;
    while (!seen && cnt < 100) begin
      if (ec_in_valid === 1'b1) seen = 1'b1;
      else begin @(negedge clk); cnt++; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL abort_no_request within %0d cycles", cnt); end
    @(negedge clk);
    in_valid = 1'b1; in_k = KW'(1); in_Px = W'(3); in_Py = W'(3);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (ec_in_valid !== 1'b0 || out_valid !== 1'b0 || out_inf !== 1'b0 ||
        {ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a, out_Rx, out_Ry} !== '0) begin
      errors++;
      $display("FAIL abort_outputs got ec_in_valid=%0d out_valid=%0d ec=%h out=(%0d,%0d) want 0",
               ec_in_valid, out_valid, {ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a}, out_Rx, out_Ry);
    end
    rst_n = 1'b1;
    late_rx = W'(3); late_ry = W'(3); late_vld = 1'b1;
    @(negedge clk);
    late_vld = 1'b0;
    stray = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (ec_in_valid !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray) begin errors++; $display("FAIL abort_stray_request got 1 want 0"); end
    checks++;
    if (ov_cnt != ov0) begin
      errors++; $display("FAIL abort_stray_result got %0d pulses want 0", ov_cnt - ov0);
    end
    core_en = 1'b1;
    run_op("after_abort", 2, 1, 1, 5, 1, mk(2, 2, 1'b0), 0, n, lat);
  endtask

  task automatic test_random();
    int primes[16] = '{5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61};
    int p, a, x, y, b, k, n, lat;
    for (int t = 0; t < 8; t++) begin
      p = primes[$urandom_range(0, 15)];
      do begin
        x = $urandom_range(0, p - 1);
        y = $urandom_range(0, p - 1);
        a = $urandom_range(0, p - 1);
        b = md(y * y - x * x * x - a * x, p);
      end while (md(4 * a * a * a + 27 * b * b, p) == 0);
      k = $urandom_range(0, 63);
      run_op("random", k, x, y, p, a, ec_mul(k, mk(x, y, 1'b0), p, a), 0, n, lat);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_k = '0; in_Px = '0; in_Py = '0;
    in_prime = '0; in_a = '0;
    late_vld = 1'b0; late_rx = '0; late_ry = '0;
    core_en = 1'b1; script_en = 1'b0; script_pt = mk(0, 0, 1'b0);
    test_reset();
    test_basic();
    test_infinity();
    test_back_to_back();
    test_reset_abort();
    test_random();
    checks++;
    if (idle_bad != 0) begin
      errors++; $display("FAIL idle_outputs_nonzero got %0d cycles want 0", idle_bad);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
